// File: rtl/dmem_access.sv
// dmem_access: data-memory access controller for the MEM stage.
//
// Accepts one load/store at a time from EX and drives an SRAM-like bus with a
// split handshake: a request phase closed by data_addr_ok, then a response
// phase closed by data_data_ok. Misaligned accesses never reach the bus; they
// raise a one-cycle address-error pulse instead. Completed ops are reported on
// the wb_* outputs for the downstream load extractor.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ex_valid          EX presents a memory op
//   ex_op[7:0]        one-hot {sw,sh,sb,lw,lhu,lh,lbu,lb} (bit 7 .. bit 0)
//   ex_addr[31:0]     effective byte address
//   ex_wdata[31:0]    store source value
//   flush             cancels the op in flight
//   ex_ready          op accepted this cycle (combinational)
//   data_req          bus request, held until data_addr_ok
//   data_wr           1 = store
//   data_size[1:0]    0 byte, 1 half, 2 word
//   data_addr[31:0]   unaligned byte address
//   data_wstrb[3:0]   byte enables, 0000 for loads
//   data_wdata[31:0]  store data replicated across byte lanes
//   data_addr_ok      bus accepted the request
//   data_data_ok      read data / write ack valid
//   data_rdata[31:0]  raw read word
//   wb_valid          one-cycle completion pulse
//   wb_is_load        completed op was a load
//   wb_word[31:0]     raw read word (0 for stores)
//   wb_adrl[1:0]      addr[1:0] of the completed op
//   wb_lubhw_con[4:0] ex_op[4:0] of the completed op
//   adel, ades        load / store address-error pulses
//   badvaddr[31:0]    faulting address, held until the next fault

module dmem_access (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid,
    input  logic [7:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        flush,
    output logic        ex_ready,

    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,

    output logic        wb_valid,
    output logic        wb_is_load,
    output logic [31:0] wb_word,
    output logic [1:0]  wb_adrl,
    output logic [4:0]  wb_lubhw_con,

    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e state_q, state_d;

    // Request captured at accept; drives the bus directly so it stays stable
    // for the whole request phase.
    logic [31:0] req_addr_q,  req_addr_d;
    logic [1:0]  req_size_q,  req_size_d;
    logic        req_wr_q,    req_wr_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [4:0]  req_con_q,   req_con_d;

    // Completion / exception outputs.
    logic        wb_valid_q,   wb_valid_d;
    logic        wb_is_load_q, wb_is_load_d;
    logic [31:0] wb_word_q,    wb_word_d;
    logic [1:0]  wb_adrl_q,    wb_adrl_d;
    logic [4:0]  wb_con_q,     wb_con_d;
    logic        adel_q,       adel_d;
    logic        ades_q,       ades_d;
    logic [31:0] badvaddr_q,   badvaddr_d;

    // Decode of the incoming op.
    logic       op_load, op_store, op_half, op_word, op_none, misaligned;
    logic [1:0] op_size;
    logic [3:0] op_wstrb;
    logic [31:0] op_wdata;

    always_comb begin
        op_load    = |ex_op[4:0];
        op_store   = |ex_op[7:5];
        op_half    = ex_op[2] | ex_op[3] | ex_op[6];
        op_word    = ex_op[4] | ex_op[7];
        op_none    = (ex_op == 8'h00);
        misaligned = (op_half & ex_addr[0]) | (op_word & (ex_addr[1:0] != 2'b00));

        if (op_word) begin
            op_size = 2'd2;
        end else if (op_half) begin
            op_size = 2'd1;
        end else begin
            op_size = 2'd0;
        end

        op_wstrb = 4'b0000;
        op_wdata = 32'h0000_0000;
        if (ex_op[5]) begin
            op_wstrb = 4'b0001 << ex_addr[1:0];
            op_wdata = {4{ex_wdata[7:0]}};
        end else if (ex_op[6]) begin
            op_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
            op_wdata = {2{ex_wdata[15:0]}};
        end else if (ex_op[7]) begin
            op_wstrb = 4'b1111;
            op_wdata = ex_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_size_d   = req_size_q;
        req_wr_d     = req_wr_q;
        req_wstrb_d  = req_wstrb_q;
        req_wdata_d  = req_wdata_q;
        req_con_d    = req_con_q;
        wb_valid_d   = 1'b0;
        wb_is_load_d = wb_is_load_q;
        wb_word_d    = wb_word_q;
        wb_adrl_d    = wb_adrl_q;
        wb_con_d     = wb_con_q;
        adel_d       = 1'b0;
        ades_d       = 1'b0;
        badvaddr_d   = badvaddr_q;

        case (state_q)
            StIdle: begin
                // An all-zero op is swallowed without side effects.
                if (ex_valid && !flush && !op_none) begin
                    if (misaligned) begin
                        adel_d     = op_load;
                        ades_d     = op_store;
                        badvaddr_d = ex_addr;
                    end else begin
                        req_addr_d  = ex_addr;
                        req_size_d  = op_size;
                        req_wr_d    = op_store;
                        req_wstrb_d = op_wstrb;
                        req_wdata_d = op_wdata;
                        req_con_d   = ex_op[4:0];
                        state_d     = StReq;
                    end
                end
            end

            StReq: begin
                // data_data_ok cannot legally arrive here and is ignored.
                if (data_addr_ok) begin
                    state_d = flush ? StDrop : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end

            StWait: begin
                if (flush) begin
                    // A response coinciding with the flush is simply discarded.
                    state_d = data_data_ok ? StIdle : StDrop;
                end else if (data_data_ok) begin
                    state_d      = StIdle;
                    wb_valid_d   = 1'b1;
                    wb_is_load_d = ~req_wr_q;
                    wb_word_d    = req_wr_q ? 32'h0000_0000 : data_rdata;
                    wb_adrl_d    = req_addr_q[1:0];
                    wb_con_d     = req_con_q;
                end
            end

            StDrop: begin
                // The bus still owes a response; swallow it before reusing the bus.
                if (data_data_ok) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_addr_q   <= 32'h0000_0000;
            req_size_q   <= 2'd0;
            req_wr_q     <= 1'b0;
            req_wstrb_q  <= 4'b0000;
            req_wdata_q  <= 32'h0000_0000;
            req_con_q    <= 5'b00000;
            wb_valid_q   <= 1'b0;
            wb_is_load_q <= 1'b0;
            wb_word_q    <= 32'h0000_0000;
            wb_adrl_q    <= 2'b00;
            wb_con_q     <= 5'b00000;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            badvaddr_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_size_q   <= req_size_d;
            req_wr_q     <= req_wr_d;
            req_wstrb_q  <= req_wstrb_d;
            req_wdata_q  <= req_wdata_d;
            req_con_q    <= req_con_d;
            wb_valid_q   <= wb_valid_d;
            wb_is_load_q <= wb_is_load_d;
            wb_word_q    <= wb_word_d;
            wb_adrl_q    <= wb_adrl_d;
            wb_con_q     <= wb_con_d;
            adel_q       <= adel_d;
            ades_q       <= ades_d;
            badvaddr_q   <= badvaddr_d;
        end
    end

    // Outputs.
    assign ex_ready     = (state_q == StIdle) & ~rst;
    assign data_req     = (state_q == StReq);
    assign data_wr      = req_wr_q;
    assign data_size    = req_size_q;
    assign data_addr    = req_addr_q;
    assign data_wstrb   = req_wstrb_q;
    assign data_wdata   = req_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_is_load   = wb_is_load_q;
    assign wb_word      = wb_word_q;
    assign wb_adrl      = wb_adrl_q;
    assign wb_lubhw_con = wb_con_q;
    assign adel         = adel_q;
    assign ades         = ades_q;
    assign badvaddr     = badvaddr_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed testbench for dmem_access. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.

module tb_dmem_access;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [7:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        flush;
    logic        ex_ready;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_valid;
    logic        wb_is_load;
    logic [31:0] wb_word;
    logic [1:0]  wb_adrl;
    logic [4:0]  wb_lubhw_con;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    int unsigned n_vec;
    int unsigned n_err;

    dmem_access dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_op        (ex_op),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .wb_valid     (wb_valid),
        .wb_is_load   (wb_is_load),
        .wb_word      (wb_word),
        .wb_adrl      (wb_adrl),
        .wb_lubhw_con (wb_lubhw_con),
        .adel         (adel),
        .ades         (ades),
        .badvaddr     (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present an op for one cycle; it is accepted at the next rising edge.
    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = wd;
        #1;
        check("accept_ready", {31'd0, ex_ready}, 32'd1);
        step();
        ex_valid = 1'b0;
    endtask

    // From REQ: immediate addr_ok, then immediate data_ok; returns in the wb cycle.
    task automatic finish_bus(input logic [31:0] rdata);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        step();
        data_data_ok = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        ex_valid     = 1'b0;
        ex_op        = 8'h00;
        ex_addr      = 32'h0;
        ex_wdata     = 32'h0;
        flush        = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;

        // Reset state.
        step();
        step();
        check("rst_ready", {31'd0, ex_ready}, 32'd0);
        check("rst_req", {31'd0, data_req}, 32'd0);
        check("rst_wbv", {31'd0, wb_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, ex_ready}, 32'd1);

        // lw, best-case timing.
        step();
        issue(8'h10, 32'h1000_0004, 32'h0);
        check("lw_req", {31'd0, data_req}, 32'd1);
        check("lw_wr", {31'd0, data_wr}, 32'd0);
        check("lw_size", {30'd0, data_size}, 32'd2);
        check("lw_addr", data_addr, 32'h1000_0004);
        check("lw_wstrb", {28'd0, data_wstrb}, 32'd0);
        check("lw_busy", {31'd0, ex_ready}, 32'd0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("lw_wait_noreq", {31'd0, data_req}, 32'd0);
        check("lw_wait_nowb", {31'd0, wb_valid}, 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        step();
        data_data_ok = 1'b0;
        check("lw_wbv", {31'd0, wb_valid}, 32'd1);
        check("lw_word", wb_word, 32'hDEAD_BEEF);
        check("lw_adrl", {30'd0, wb_adrl}, 32'd0);
        check("lw_con", {27'd0, wb_lubhw_con}, 32'b10000);
        check("lw_isld", {31'd0, wb_is_load}, 32'd1);
        check("lw_ready", {31'd0, ex_ready}, 32'd1);
        step();
        check("lw_wbv_pulse", {31'd0, wb_valid}, 32'd0);
        check("lw_word_hold", wb_word, 32'hDEAD_BEEF);

        // sb to byte 3.
        issue(8'h20, 32'h2000_0003, 32'h0000_00A5);
        check("sb_wstrb", {28'd0, data_wstrb}, 32'b1000);
        check("sb_wdata", data_wdata, 32'hA5A5_A5A5);
        check("sb_size", {30'd0, data_size}, 32'd0);
        check("sb_wr", {31'd0, data_wr}, 32'd1);
        finish_bus(32'h5555_5555);
        check("sb_wbv", {31'd0, wb_valid}, 32'd1);
        check("sb_isld", {31'd0, wb_is_load}, 32'd0);
        check("sb_word", wb_word, 32'h0);
        check("sb_adrl", {30'd0, wb_adrl}, 32'd3);
        check("sb_con", {27'd0, wb_lubhw_con}, 32'd0);
        step();

        // sh to upper half.
        issue(8'h40, 32'h2000_0002, 32'h1234_ABCD);
        check("sh_wstrb", {28'd0, data_wstrb}, 32'b1100);
        check("sh_wdata", data_wdata, 32'hABCD_ABCD);
        check("sh_size", {30'd0, data_size}, 32'd1);
        finish_bus(32'h0);
        check("sh_wbv", {31'd0, wb_valid}, 32'd1);
        step();

        // Misaligned lh -> adel, no bus activity.
        issue(8'h04, 32'h3000_0001, 32'h0);
        check("lh_adel", {31'd0, adel}, 32'd1);
        check("lh_ades", {31'd0, ades}, 32'd0);
        check("lh_bad", badvaddr, 32'h3000_0001);
        check("lh_noreq", {31'd0, data_req}, 32'd0);
        check("lh_ready", {31'd0, ex_ready}, 32'd1);
        step();
        check("lh_adel_pulse", {31'd0, adel}, 32'd0);
        check("lh_noreq2", {31'd0, data_req}, 32'd0);
        check("lh_nowb", {31'd0, wb_valid}, 32'd0);

        // Misaligned sw -> ades.
        issue(8'h80, 32'h3000_0002, 32'h0);
        check("sw_ades", {31'd0, ades}, 32'd1);
        check("sw_adel", {31'd0, adel}, 32'd0);
        check("sw_bad", badvaddr, 32'h3000_0002);
        check("sw_noreq", {31'd0, data_req}, 32'd0);
        step();

        // ex_op == 0 is accepted without effect.
        issue(8'h00, 32'h3000_0003, 32'h0);
        check("nop_noreq", {31'd0, data_req}, 32'd0);
        check("nop_adel", {31'd0, adel}, 32'd0);
        check("nop_ready", {31'd0, ex_ready}, 32'd1);

        // lhu with addr_ok stalled three cycles.
        issue(8'h08, 32'h4000_0006, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("stall_req", {31'd0, data_req}, 32'd1);
            check("stall_addr", data_addr, 32'h4000_0006);
            check("stall_size", {30'd0, data_size}, 32'd1);
            check("stall_ready", {31'd0, ex_ready}, 32'd0);
            step();
        end
        check("stall_req_last", {31'd0, data_req}, 32'd1);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("stall_wait_ready", {31'd0, ex_ready}, 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'h1122_3344;
        step();
        data_data_ok = 1'b0;
        check("stall_wbv", {31'd0, wb_valid}, 32'd1);
        check("stall_word", wb_word, 32'h1122_3344);
        check("stall_adrl", {30'd0, wb_adrl}, 32'd2);
        check("stall_con", {27'd0, wb_lubhw_con}, 32'b01000);
        step();

        // lb flushed in WAIT; response arrives two cycles later and is dropped.
        issue(8'h01, 32'h5000_0001, 32'h0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        ex_valid = 1'b1;
        ex_op    = 8'h02;
        ex_addr  = 32'h6000_0002;
        #1;
        check("drop_ready", {31'd0, ex_ready}, 32'd0);
        check("drop_nowb", {31'd0, wb_valid}, 32'd0);
        step();
        check("drop_ready2", {31'd0, ex_ready}, 32'd0);
        check("drop_noreq", {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        step();
        data_data_ok = 1'b0;
        check("drop_nowb2", {31'd0, wb_valid}, 32'd0);
        check("drop_word_hold", wb_word, 32'h1122_3344);
        check("lbu_ready", {31'd0, ex_ready}, 32'd1);
        step();
        ex_valid = 1'b0;
        check("lbu_req", {31'd0, data_req}, 32'd1);
        check("lbu_addr", data_addr, 32'h6000_0002);
        finish_bus(32'hCAFE_F00D);
        check("lbu_wbv", {31'd0, wb_valid}, 32'd1);
        check("lbu_word", wb_word, 32'hCAFE_F00D);
        check("lbu_adrl", {30'd0, wb_adrl}, 32'd2);
        check("lbu_con", {27'd0, wb_lubhw_con}, 32'b00010);
        step();

        // Reset while in WAIT.
        issue(8'h10, 32'h7000_0008, 32'h0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        check("rstw_ready", {31'd0, ex_ready}, 32'd0);
        step();
        check("rstw_req", {31'd0, data_req}, 32'd0);
        check("rstw_addr", data_addr, 32'h0);
        check("rstw_wbv", {31'd0, wb_valid}, 32'd0);
        check("rstw_word", wb_word, 32'h0);
        check("rstw_con", {27'd0, wb_lubhw_con}, 32'd0);
        check("rstw_bad", badvaddr, 32'h0);
        rst = 1'b0;
        #1;
        check("rstw_ready_after", {31'd0, ex_ready}, 32'd1);
        step();

        // sw after reset works normally.
        issue(8'h80, 32'h7000_000C, 32'h89AB_CDEF);
        check("sw_wstrb", {28'd0, data_wstrb}, 32'hF);
        check("sw_wdata", data_wdata, 32'h89AB_CDEF);
        finish_bus(32'h0);
        check("sw_wbv", {31'd0, wb_valid}, 32'd1);
        check("sw_isld", {31'd0, wb_is_load}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_access.md
# dmem_access

Data-memory access controller for the MEM stage. It takes one load or store per request from EX and drives the SRAM-like data bus (req/addr_ok/data_ok split handshake). It detects misaligned addresses and generates byte strobes and replicated store data. Load results are registered and handed, with address low bits and a one-hot load-type vector, to the downstream load extractor (lb/lbu/lh/lhu/lw sign/zero-extension).

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  memory op presented by EX
- ex_op  in  8  one-hot {0:lb,1:lbu,2:lh,3:lhu,4:lw,5:sb,6:sh,7:sw}
- ex_addr  in  32  effective address
- ex_wdata  in  32  store source register value
- flush  in  1  exception/pipeline flush; cancels the current op
- ex_ready  out  1  op accepted this cycle (combinational)
- data_req  out  1  bus request
- data_wr  out  1  1=store
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  32  full unaligned byte address
- data_wstrb  out  4  byte enables (0000 for loads)
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted by bus
- data_data_ok  in  1  response/write-ack valid
- data_rdata  in  32  raw read word
- wb_valid  out  1  one-cycle completion pulse
- wb_is_load  out  1  completed op was a load
- wb_word  out  32  raw word for the extractor
- wb_adrl  out  2  addr[1:0] of the completed op
- wb_lubhw_con  out  5  ex_op[4:0] of the completed op
- adel  out  1  load address-error pulse
- ades  out  1  store address-error pulse
- badvaddr  out  32  faulting address (valid with adel/ades)

## Operation
- FSM states: IDLE, REQ, WAIT, DROP. Reset → IDLE. All registered outputs reset to 0.
- ex_ready = (state==IDLE) & ~rst. While rst is high, ex_ready=0.
- IDLE & ex_valid & ~flush:
  - Misaligned if half op with addr[0]=1, or word op with addr[1:0]≠0. In that case the op is accepted with no bus request; next cycle adel (loads) or ades (stores) pulses for 1 cycle with badvaddr=ex_addr, and wb_valid stays 0.
  - ex_op==0 is accepted with no effect.
  - Otherwise latch op/addr/wdata and go to REQ.
- REQ: data_req=1; addr/size/wr/wstrb/wdata are held stable until addr_ok.
  - addr_ok & ~flush → WAIT.
  - addr_ok & flush → DROP.
  - flush & ~addr_ok → IDLE; req drops the next cycle.
- WAIT: on data_ok & ~flush, capture data_rdata (loads) into wb_word and go to IDLE. wb_valid pulses the following cycle. flush before data_ok → DROP.
- DROP: wait for data_ok, discard the response, go to IDLE, no wb_valid. flush in DROP has no further effect.
- Store strobes/data:
  - sb: wstrb = 0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: wstrb = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 1111; wdata unchanged.
- Stores complete on data_ok with wb_valid=1, wb_is_load=0, wb_word=0.
- wb_word/wb_adrl/wb_lubhw_con hold their values until the next completion.
- At most one outstanding transaction; no new accept until back in IDLE.

## Timing
- Best case: cycle 0 accept (ex_ready & ex_valid); cycle 1 data_req=1, addr_ok=1; cycle 2 data_ok=1; cycle 3 wb_valid=1. Total 3-cycle latency.
- Each cycle of addr_ok or data_ok delay adds 1 cycle.
- Misaligned op: adel/ades in cycle 1, ex_ready again in cycle 1.
- data_ok arriving in REQ is not possible (bus protocol) and is ignored.
- rst mid-transaction returns to IDLE next edge. The bus is required to be reset on the same rst.

## Test plan
- lw 0x1000_0004, addr_ok and data_ok immediate, rdata=0xDEADBEEF → wb_valid in cycle 3, wb_word=0xDEADBEEF, wb_adrl=00, wb_lubhw_con=10000.
- sb addr 0x...0003, wdata=0x000000A5 → data_wstrb=1000, data_wdata=0xA5A5A5A5, data_size=0, data_wr=1. sh addr ...02 → wstrb=1100.
- lh addr ...01 → adel=1 for 1 cycle, badvaddr=addr, data_req never 1. sw addr ...02 → ades=1.
- addr_ok stalled 3 cycles → data_req and data_addr stable throughout; ex_ready=0 until completion.
- flush in WAIT, data_ok 2 cycles later → no wb_valid. The next lbu is accepted only after that data_ok, and returns the correct word.
- rst asserted in WAIT → all outputs 0 next cycle, state IDLE, ex_ready=1 after rst deasserts.
